// File: rtl/ray_job_scheduler.sv
// ray_job_scheduler
//   Shares one single-ray raytracer core among NUM_REQ requesters using round-robin
//   arbitration. Jobs are issued one at a time. Each result is held as a
//   requester-tagged response. A watchdog turns a hung core into an error response
//   and a core reset pulse. Scene loading takes priority over ray traffic.
// Ports
//   clk, rst                      : clock; synchronous active-high reset
//   req_valid/req_ready/req_job   : per-requester job input; req_ready is a one-hot accept
//   core_job_valid/ready, core_job: job issue handshake to the core
//   core_ray_done/hit/timeout/res : one-cycle result strobe, flags and payload from the core
//   core_rst                      : reset pulse to the core after a watchdog expiry
//   res_valid/ready, res_*        : held response to the front end
//   load_req/grant/done           : scene loader arbitration
//   busy, ray_count, wdog_count   : status; ray_count wraps, wdog_count saturates
module ray_job_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned JOB_W           = 220,
  parameter int unsigned RES_W           = 67,
  parameter int unsigned WDOG_CYCLES     = 65536,
  parameter int unsigned CORE_RST_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*JOB_W-1:0]     req_job,
  output logic                         core_job_valid,
  input  logic                         core_job_ready,
  output logic [JOB_W-1:0]             core_job,
  input  logic                         core_ray_done,
  input  logic                         core_ray_hit,
  input  logic                         core_ray_timeout,
  input  logic [RES_W-1:0]             core_res,
  output logic                         core_rst,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                         res_hit,
  output logic                         res_timeout,
  output logic                         res_wdog,
  output logic [RES_W-1:0]             res_payload,
  input  logic                         load_req,
  output logic                         load_grant,
  input  logic                         load_done,
  output logic                         busy,
  output logic [15:0]                  ray_count,
  output logic [7:0]                   wdog_count
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES);
  localparam int unsigned RC_W = $clog2(CORE_RST_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, LOAD} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [JOB_W-1:0]   core_job_q, core_job_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic               res_hit_q, res_hit_d;
  logic               res_timeout_q, res_timeout_d;
  logic               res_wdog_q, res_wdog_d;
  logic [RES_W-1:0]   res_payload_q, res_payload_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [15:0]        ray_count_q, ray_count_d;
  logic [7:0]         wdog_count_q, wdog_count_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    core_job_d    = core_job_q;
    res_id_d      = res_id_q;
    res_hit_d     = res_hit_q;
    res_timeout_d = res_timeout_q;
    res_wdog_d    = res_wdog_q;
    res_payload_d = res_payload_q;
    wd_d          = wd_q;
    rst_cnt_d     = (rst_cnt_q != '0) ? rst_cnt_q - RC_W'(1) : '0;
    ray_count_d   = ray_count_q;
    wdog_count_d  = wdog_count_q;
    req_ready     = '0;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = LOAD;
        end else if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          core_job_d = req_job[32'(grant_idx) * JOB_W +: JOB_W];
          res_id_d   = grant_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (core_job_ready) begin
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        wd_d = wd_q + WD_W'(1);
        // A done in the expiry cycle still returns the real result.
        if (core_ray_done) begin
          res_hit_d     = core_ray_hit;
          res_timeout_d = core_ray_timeout;
          res_payload_d = core_res;
          res_wdog_d    = 1'b0;
          state_d       = RESP;
        end else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
          res_hit_d     = 1'b0;
          res_timeout_d = 1'b0;
          res_payload_d = '0;
          res_wdog_d    = 1'b1;
          rst_cnt_d     = RC_W'(CORE_RST_CYCLES);
          if (wdog_count_q != 8'hFF) begin
            wdog_count_d = wdog_count_q + 8'd1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        // res_ready is not taken while the core is still held in reset.
        if (res_ready && rst_cnt_q == '0) begin
          ray_count_d = ray_count_q + 16'd1;
          rr_ptr_d    = (res_id_q == ID_W'(NUM_REQ - 1)) ? '0 : res_id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      LOAD: begin
        if (load_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      core_job_q    <= '0;
      res_id_q      <= '0;
      res_hit_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      res_wdog_q    <= 1'b0;
      res_payload_q <= '0;
      wd_q          <= '0;
      rst_cnt_q     <= '0;
      ray_count_q   <= '0;
      wdog_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      core_job_q    <= core_job_d;
      res_id_q      <= res_id_d;
      res_hit_q     <= res_hit_d;
      res_timeout_q <= res_timeout_d;
      res_wdog_q    <= res_wdog_d;
      res_payload_q <= res_payload_d;
      wd_q          <= wd_d;
      rst_cnt_q     <= rst_cnt_d;
      ray_count_q   <= ray_count_d;
      wdog_count_q  <= wdog_count_d;
    end
  end

  assign core_job_valid = (state_q == ISSUE);
  assign core_job       = core_job_q;
  assign core_rst       = (rst_cnt_q != '0);
  assign res_valid      = (state_q == RESP);
  assign res_id         = res_id_q;
  assign res_hit        = res_hit_q;
  assign res_timeout    = res_timeout_q;
  assign res_wdog       = res_wdog_q;
  assign res_payload    = res_payload_q;
  assign load_grant     = (state_q == LOAD);
  assign busy           = (state_q != IDLE);
  assign ray_count      = ray_count_q;
  assign wdog_count     = wdog_count_q;

endmodule

// File: tb/tb_ray_job_scheduler.sv
// Bench for ray_job_scheduler: directed scenarios with literal expectations, then
// randomized traffic. A cycle-level reference model checks every cycle.
module tb_ray_job_scheduler;

  localparam int NR = 4;
  localparam int JW = 220;
  localparam int RW = 67;
  localparam int WD = 16;
  localparam int CR = 4;

  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_BUSY = 2, PH_RESP = 3, PH_LOAD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*JW-1:0] req_job;
  logic             core_job_valid, core_job_ready;
  logic [JW-1:0]    core_job;
  logic             core_ray_done, core_ray_hit, core_ray_timeout;
  logic [RW-1:0]    core_res;
  logic             core_rst, res_valid, res_ready;
  logic [1:0]       res_id;
  logic             res_hit, res_timeout, res_wdog;
  logic [RW-1:0]    res_payload;
  logic             load_req, load_grant, load_done, busy;
  logic [15:0]      ray_count;
  logic [7:0]       wdog_count;

  ray_job_scheduler #(.NUM_REQ(NR), .JOB_W(JW), .RES_W(RW), .WDOG_CYCLES(WD), .CORE_RST_CYCLES(CR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_job(req_job),
    .core_job_valid(core_job_valid), .core_job_ready(core_job_ready), .core_job(core_job),
    .core_ray_done(core_ray_done), .core_ray_hit(core_ray_hit), .core_ray_timeout(core_ray_timeout),
    .core_res(core_res), .core_rst(core_rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_hit(res_hit), .res_timeout(res_timeout), .res_wdog(res_wdog),
    .res_payload(res_payload), .load_req(load_req), .load_grant(load_grant), .load_done(load_done),
    .busy(busy), .ray_count(ray_count), .wdog_count(wdog_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int grant_log[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [JW-1:0] rand_job();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t = {t[191:0], $urandom()};
    return t[JW-1:0];
  endfunction

  function automatic logic [RW-1:0] rand_res();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int start);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (start + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // ---------------- reference model ----------------
  bit            m_valid = 0;
  int            m_phase, m_id, m_rr, m_rays, m_wdogs;
  logic [JW-1:0] m_job;
  logic          m_hit, m_to, m_wd;
  logic [RW-1:0] m_pay;
  longint        cyc = 0, busy_start = 0, rst_first = 0, rst_last = -1;

  always @(posedge clk) begin
    longint prev;
    int g;
    prev = cyc;
    cyc  = cyc + 1;
    if (rst) begin
      m_valid = 1; m_phase = PH_IDLE; m_id = 0; m_rr = 0; m_rays = 0; m_wdogs = 0;
      m_job = '0; m_hit = 0; m_to = 0; m_wd = 0; m_pay = '0; rst_first = 0; rst_last = -1;
    end else if (m_valid) begin
      case (m_phase)
        PH_IDLE: begin
          g = pick(req_valid, m_rr);
          if (load_req) m_phase = PH_LOAD;
          else if (g >= 0) begin
            m_job = req_job[g*JW +: JW]; m_id = g; m_phase = PH_ISSUE;
          end
        end
        PH_ISSUE: if (core_job_ready) begin m_phase = PH_BUSY; busy_start = cyc; end
        PH_BUSY: begin
          if (core_ray_done) begin
            m_hit = core_ray_hit; m_to = core_ray_timeout; m_pay = core_res; m_wd = 0; m_phase = PH_RESP;
          end else if (prev - busy_start == WD - 1) begin
            m_hit = 0; m_to = 0; m_pay = '0; m_wd = 1; m_phase = PH_RESP;
            rst_first = cyc; rst_last = cyc + CR - 1;
            if (m_wdogs < 255) m_wdogs++;
          end
        end
        PH_RESP: begin
          if (res_ready && !(prev >= rst_first && prev <= rst_last)) begin
            m_rays = (m_rays + 1) % 65536; m_rr = (m_id + 1) % NR; m_phase = PH_IDLE;
          end
        end
        default: if (load_done) m_phase = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int g;
      logic [NR-1:0] er;
      logic          rst_on;
      er = '0;
      g  = pick(req_valid, m_rr);
      if (m_phase == PH_IDLE && !load_req && g >= 0) er[g] = 1'b1;
      rst_on = (cyc >= rst_first && cyc <= rst_last);
      check("req_ready", req_ready, er);
      check("ctrl", {core_job_valid, res_valid, load_grant, busy, core_rst},
            {m_phase == PH_ISSUE, m_phase == PH_RESP, m_phase == PH_LOAD, m_phase != PH_IDLE, rst_on});
      check("core_job", core_job, m_job);
      check("res_fields", {res_id, res_hit, res_timeout, res_wdog}, {m_id[1:0], m_hit, m_to, m_wd});
      check("res_payload", res_payload, m_pay);
      check("counters", {ray_count, wdog_count}, {m_rays[15:0], m_wdogs[7:0]});
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NR; i++) if (req_ready[i]) grant_log.push_back(i);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic wait_grant(input logic [NR-1:0] exp_mask, input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin ok = 1; break; end
    end
    if (ok) check(name, req_ready, exp_mask);
    else begin
      checks++; errors++;
      $display("FAIL %s: no req_ready within 20 cycles, expected %0h", name, exp_mask);
    end
    step();
  endtask

  // Core answers 3 cycles after each issue handshake; responses are taken at once.
  task automatic auto_run(input int want);
    int cd;
    bit hs, ok;
    cd = 0; ok = 0;
    core_job_ready = 1; res_ready = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (core_job_valid && grant_log.size() > 0)
        check("rr_core_job", core_job, req_job[grant_log[$]*JW +: JW]);
      hs = core_job_valid && core_job_ready;
      step();
      if (grant_log.size() >= want && req_valid == '0 && !busy) begin ok = 1; break; end
      core_ray_done = 0;
      if (hs) cd = 2;
      else if (cd > 0) begin cd--; if (cd == 0) core_ray_done = 1; end
      if (grant_log.size() >= want) req_valid = '0;
    end
    core_job_ready = 0; res_ready = 0; core_ray_done = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL auto_run: %0d grants seen within 200 cycles, required %0d", grant_log.size(), want);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [JW-1:0] job0;
    logic [RW-1:0] pay;
    int first, rst_hi;

    rst = 1; req_valid = '0; core_job_ready = 0; core_ray_done = 0; core_ray_hit = 0;
    core_ray_timeout = 0; core_res = '0; res_ready = 0; load_req = 0; load_done = 0;
    for (int i = 0; i < NR; i++) req_job[i*JW +: JW] = rand_job();
    step(); step();
    @(negedge clk);
    check("reset_outputs", {req_ready, core_job_valid, core_rst, res_valid, res_hit, res_timeout,
                            res_wdog, load_grant, busy, ray_count, wdog_count}, '0);
    check("reset_data", {core_job, res_id, res_payload}, '0);
    step(); rst = 0;

    // Single requester
    grant_log.delete();
    req_valid = 4'b0100; core_job_ready = 1;
    wait_grant(4'b0100, "single_grant");
    req_valid = '0;
    step();                                     // BUSY entry
    repeat (10) step();
    core_ray_done = 1; core_ray_hit = 1; core_ray_timeout = 0;
    core_res = {16'd5, 16'd0, 16'd0, 3'd1, 16'd5};
    step();
    core_ray_done = 0; core_ray_hit = 0; core_res = rand_res();
    @(negedge clk);
    check("single_resp", {res_valid, res_id, res_hit, res_timeout, res_wdog}, {1'b1, 2'd2, 1'b1, 1'b0, 1'b0});
    check("single_payload", res_payload, {16'd5, 16'd0, 16'd0, 3'd1, 16'd5});
    res_ready = 1; step(); res_ready = 0; core_job_ready = 0;
    @(negedge clk);
    check("single_ray_count", ray_count, 16'd1);
    check("single_one_pulse", {grant_log.size(), grant_log[0]}, {32'd1, 32'd2});

    // Round robin
    do_reset();
    grant_log.delete();
    req_valid = 4'hF;
    auto_run(5);
    for (int k = 0; k < 5; k++) check("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % NR);

    // Backpressure
    job0 = rand_job();
    req_job[0 +: JW] = job0; req_valid = 4'b0001; core_job_ready = 0; res_ready = 0;
    wait_grant(4'b0001, "bp_grant");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_job_valid", core_job_valid, 1'b1);
      check("bp_job_stable", core_job, job0);
      step();
      req_job[0 +: JW] = rand_job();
    end
    core_job_ready = 1; step(); core_job_ready = 0;
    step();
    pay = rand_res();
    core_ray_done = 1; core_ray_hit = 0; core_ray_timeout = 1; core_res = pay;
    step();
    core_ray_done = 0; core_ray_timeout = 0; core_res = rand_res();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("bp_resp_stable", {res_valid, res_id, res_hit, res_timeout, res_wdog, res_payload},
            {1'b1, 2'd0, 1'b0, 1'b1, 1'b0, pay});
      check("bp_no_accept", req_ready, 4'b0000);
      step();
    end
    res_ready = 1; req_valid = '0; step(); res_ready = 0;

    // Watchdog
    do_reset();
    req_valid = 4'b0001; core_job_ready = 1; res_ready = 1;
    wait_grant(4'b0001, "wd_grant");
    req_valid = '0;
    step();                                     // BUSY entry cycle, k = 0
    first = -1; rst_hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (res_valid && first < 0) begin
        first = k;
        check("wd_resp", {res_wdog, res_hit, res_timeout, res_payload}, {1'b1, 1'b0, 1'b0, 67'd0});
      end
      if (core_rst) rst_hi++;
      step();
    end
    check("wd_latency", first, 16);
    check("wd_rst_len", rst_hi, 4);
    check("wd_count", {wdog_count, busy}, {8'd1, 1'b0});
    res_ready = 0;
    req_valid = 4'b0001;
    wait_grant(4'b0001, "wd2_grant");
    req_valid = '0;
    step();
    repeat (WD - 1) step();                     // expiry cycle
    pay = rand_res();
    core_ray_done = 1; core_ray_hit = 1; core_res = pay;
    step();
    core_ray_done = 0; core_ray_hit = 0;
    @(negedge clk);
    check("wd_done_wins", {res_valid, res_wdog, res_hit, core_rst, wdog_count}, {1'b1, 1'b0, 1'b1, 1'b0, 8'd1});
    check("wd_done_payload", res_payload, pay);
    res_ready = 1; step(); res_ready = 0;

    // Load arbitration
    load_req = 1; req_valid = 4'b0001; core_job_ready = 1;
    @(negedge clk);
    check("ld_prio", {load_grant, req_ready}, 5'b0);
    step(); load_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ld_active", {load_grant, req_ready}, 5'b10000);
      step();
    end
    load_done = 1;
    @(negedge clk);
    check("ld_done_cycle", load_grant, 1'b1);
    step(); load_done = 0;
    @(negedge clk);
    check("ld_then_req0", {load_grant, req_ready}, 5'b00001);
    step(); req_valid = '0;
    step(); load_req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ld_wait_busy", {load_grant, busy}, 2'b01);
      step();
    end
    core_ray_done = 1; step(); core_ray_done = 0;
    @(negedge clk);
    check("ld_wait_resp", {res_valid, load_grant}, 2'b10);
    res_ready = 1; step(); res_ready = 0;
    @(negedge clk);
    check("ld_after_resp_idle", {load_grant, busy}, 2'b00);
    step();
    @(negedge clk);
    check("ld_after_resp_grant", load_grant, 1'b1);
    step(); load_req = 0; load_done = 1;
    step(); load_done = 0;

    // Reset mid-BUSY
    req_job[1*JW +: JW] = rand_job();
    req_valid = 4'b0010; core_job_ready = 1;
    wait_grant(4'b0010, "mrst_grant");
    req_valid = '0;
    step(); step();
    rst = 1; step(); rst = 0;
    @(negedge clk);
    check("mrst_ctrl", {req_ready, core_job_valid, core_rst, res_valid, res_hit, res_timeout,
                        res_wdog, load_grant, busy, ray_count, wdog_count}, '0);
    check("mrst_data", {core_job, res_id, res_payload}, '0);
    step();
    core_ray_done = 1; core_ray_hit = 1; step(); core_ray_done = 0; core_ray_hit = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mrst_stray_done", {res_valid, busy}, 2'b00);
      step();
    end
    core_job_ready = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      req_valid = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom());
      if ($urandom_range(0, 3) == 0) req_job[$urandom_range(0, NR-1)*JW +: JW] = rand_job();
      core_job_ready   = 1'($urandom_range(0, 1));
      core_ray_done    = ($urandom_range(0, 7) == 0);
      core_ray_hit     = 1'($urandom_range(0, 1));
      core_ray_timeout = 1'($urandom_range(0, 1));
      core_res         = rand_res();
      res_ready        = 1'($urandom_range(0, 1));
      load_req         = ($urandom_range(0, 15) == 0);
      load_done        = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 0; req_valid = '0; core_ray_done = 0; load_req = 0; load_done = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ray_job_scheduler.md
# ray_job_scheduler

Round-robin scheduler that shares the single-ray `raytracer_top` core between `NUM_REQ` ray requesters and serializes scene loading against ray traffic. It accepts one job at a time from the requesters, issues it over the core's `job_valid`/`job_ready` handshake, and captures the one-cycle `ray_done` result into a held, requester-tagged response. A watchdog turns a hung core into an error response plus a core reset pulse. It sits between the ray-generation front end and `raytracer_top`.

## Interface
- `NUM_REQ`, 4: number of requester ports (2..8).
- `JOB_W`, 220: packed job width: {ix0[5], iy0[5], iz0[5], sx, sy, sz, next_x/y/z[32 each], inc_x/y/z[32 each], max_steps[10]}.
- `RES_W`, 67: packed result payload width: {hit_voxel_x/y/z[16 each], hit_face_id[3], steps_taken[16]}.
- `WDOG_CYCLES`, 65536: BUSY cycles allowed before the watchdog fires (≥4).
- `CORE_RST_CYCLES`, 4: length of the `core_rst` pulse.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: **synchronous, active-high** reset.
- `req_valid` in NUM_REQ: per-requester job valid.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `req_job` in NUM_REQ*JOB_W: requester i occupies bits [i*JOB_W +: JOB_W].
- `core_job_valid` out 1, `core_job_ready` in 1: job handshake to the core.
- `core_job` out JOB_W: latched job.
- `core_ray_done`, `core_ray_hit`, `core_ray_timeout` in 1 each: result strobe and flags from the core.
- `core_res` in RES_W: result payload, valid only with `core_ray_done`.
- `core_rst` out 1: active-high reset request to the core.
- `res_valid` out 1, `res_ready` in 1: response handshake.
- `res_id` out $clog2(NUM_REQ): index of the requester that owns the response.
- `res_hit`, `res_timeout`, `res_wdog` out 1 each: response flags.
- `res_payload` out RES_W: response data.
- `load_req` in 1: scene loader wants the core.
- `load_grant` out 1: loader may drive `load_mode` and `load_valid`.
- `load_done` in 1: loader finished; sampled only in LOAD.
- `busy` out 1: state ≠ IDLE.
- `ray_count` out 16: responses completed; wraps at 2^16.
- `wdog_count` out 8: watchdog events; saturates at 255.

## Operation
States: IDLE, ISSUE, BUSY, RESP, LOAD.

**IDLE**
- If `load_req`=1, go to LOAD. Loading has priority over rays.
- Otherwise, if any `req_valid` is set, pick grant g by round robin. The search starts at `rr_ptr` and moves upward with wrap.
- Drive `req_ready[g]`=1 combinationally for that one cycle. Latch `req_job[g]` into `core_job` and g into `res_id`. Go to ISSUE.

**ISSUE**
- Hold `core_job_valid`=1 with `core_job` stable until `core_job_ready`=1, then go to BUSY.
- Clear the watchdog counter on BUSY entry.

**BUSY**
- The watchdog counter increments every cycle.
- On `core_ray_done`: capture the hit, timeout and payload flags, set `res_wdog`=0, go to RESP.
- If the counter reaches WDOG_CYCLES−1 without `core_ray_done`:
  - set `res_wdog`=1, `res_hit`=0, `res_timeout`=0, `res_payload`=0;
  - drive `core_rst`=1 for CORE_RST_CYCLES cycles;
  - increment `wdog_count`;
  - go to RESP.
- If done and expiry happen in the same cycle, done wins.

**RESP**
- Hold `res_valid`=1 with all fields stable until `res_ready`=1.
- On that handshake: increment `ray_count`, set `rr_ptr`=(g+1) mod NUM_REQ, go to IDLE.
- Leave RESP only after the handshake and after the `core_rst` pulse has ended.

**LOAD**
- `load_grant`=1. On `load_done`=1, go to IDLE. `load_grant` drops in the cycle IDLE is entered.

General rules:
- `core_ray_done` outside BUSY is ignored.
- `req_ready` is never asserted outside IDLE.
- Job and payload bits are never reordered.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0;
  - `req_ready`, `core_job_valid`, `core_rst`, `res_valid`, `res_hit`, `res_timeout`, `res_wdog`, `load_grant`, `busy` all 0;
  - `core_job`, `res_id`, `res_payload` = 0; both counters 0.
- Reset during any state aborts the in-flight job and any pending response; `core_rst` deasserts.
- Accept in cycle T: `core_job_valid`=1 at T+1. If `core_job_ready`=1 at T+1, the state is BUSY at T+2.
- `core_ray_done` at cycle D: `res_valid`=1 at D+1.
- `res_ready` high at D+1: the next accept can happen at D+2.
- Watchdog fires WDOG_CYCLES cycles after BUSY entry. `core_rst` is high for cycles E+1..E+CORE_RST_CYCLES, where E is the expiry cycle.
- `load_req` at T in IDLE: `load_grant`=1 at T+1.

## Test plan
- **Single requester:** req 2 valid with a job; core returns done at BUSY+10 with hit=1, payload (5,0,0,face 1,steps 5).
  - Required: one `req_ready[2]` pulse; `res_id`=2, `res_hit`=1, payload matches; `ray_count`=1.
- **Round robin:** all 4 requesters valid continuously, core returns done 3 cycles after each issue.
  - Required: grant order 0,1,2,3,0; `core_job` matches each requester's bits.
- **Backpressure:**
  - `core_job_ready` low for 5 cycles: `core_job_valid` and `core_job` stay stable.
  - `res_ready` low for 7 cycles: response fields stay stable and no new `req_ready` is issued.
- **Watchdog:** WDOG_CYCLES=16, core never sends done.
  - Required: `res_wdog`=1, `res_hit`=0, `res_timeout`=0 exactly 16 cycles after BUSY entry; `core_rst` high for 4 cycles; `wdog_count`=1.
  - Then a done exactly at expiry returns a normal result.
- **Load arbitration:** `load_req` and `req_valid[0]` both high in IDLE.
  - Required: LOAD first with `load_grant`=1, `req_ready`=0 throughout; after `load_done`, req 0 is accepted.
  - A `load_req` arriving during BUSY waits until after the response.
- **Reset mid-BUSY:** assert `rst` for 1 cycle during BUSY.
  - Required: all outputs return to reset values next cycle; a later stray `core_ray_done` produces no response.
